// File: rtl/anim_pkg.sv
// -----------------------------------------------------------------------------
// anim_pkg
// Shared definitions for the per-player animation sequencer:
//   - sprite frame codes consumed by the renderer's ROM select
//   - character_state / move_state input encodings
//   - FSM state enum
//   - helpers that classify states and map state/frame/phase to a frame code
// Optional feature macro used by the sequencer: ANIM_INJURED_EN.
// -----------------------------------------------------------------------------
package anim_pkg;

  localparam logic [3:0] SPR_STAND  = 4'd0;
  localparam logic [3:0] SPR_WALK_F = 4'd1;
  localparam logic [3:0] SPR_WALK_B = 4'd2;
  localparam logic [3:0] SPR_PUNCH1 = 4'd3;
  localparam logic [3:0] SPR_PUNCH2 = 4'd4;
  localparam logic [3:0] SPR_PUNCH3 = 4'd5;
  localparam logic [3:0] SPR_SP1    = 4'd6;
  localparam logic [3:0] SPR_SP2    = 4'd7;
  localparam logic [3:0] SPR_SP3    = 4'd8;
  localparam logic [3:0] SPR_INJ1   = 4'd9;
  localparam logic [3:0] SPR_INJ2   = 4'd10;
  localparam logic [3:0] SPR_INJ3   = 4'd11;
  localparam logic [3:0] SPR_JUMP   = 4'd12;

  localparam logic [2:0] CS_NORMAL  = 3'b000;
  localparam logic [2:0] CS_PUNCH   = 3'b001;
  localparam logic [2:0] CS_SPECIAL = 3'b010;

  localparam logic [1:0] MV_FWD     = 2'b01;
  localparam logic [1:0] MV_BWD     = 2'b10;

  localparam logic [1:0] LAST_FRAME = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WALK_F  = 3'd1,
    ST_WALK_B  = 3'd2,
    ST_AIR     = 3'd3,
    ST_PUNCH   = 3'd4,
    ST_SPECIAL = 3'd5,
    ST_INJURED = 3'd6
  } anim_state_t;

  // One-shot states hold the lock and ignore locomotion until they finish.
  function automatic logic is_oneshot(input anim_state_t s);
    return (s == ST_PUNCH) || (s == ST_SPECIAL) || (s == ST_INJURED);
  endfunction

  function automatic logic [3:0] sprite_code(input anim_state_t s,
                                             input logic [1:0] frame,
                                             input logic       phase);
    logic [3:0] code;
    case (s)
      ST_WALK_F:  code = phase ? SPR_WALK_F : SPR_STAND;
      ST_WALK_B:  code = phase ? SPR_WALK_B : SPR_STAND;
      ST_AIR:     code = SPR_JUMP;
      ST_PUNCH:   code = SPR_PUNCH1 + {2'b00, frame};
      ST_SPECIAL: code = SPR_SP1 + {2'b00, frame};
      ST_INJURED: code = SPR_INJ1 + {2'b00, frame};
      default:    code = SPR_STAND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/anim_tick_gen.sv
// -----------------------------------------------------------------------------
// anim_tick_gen
// Animation frame tick. Counts 0 .. TICK_DIV-1 and flags the last count;
// a clear restarts the count so a new sequence always gets a full first frame.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_clear  restart count at 0 on the next edge
//   o_tick   high while count == TICK_DIV-1
// -----------------------------------------------------------------------------
module anim_tick_gen #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int             CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;

  assign o_tick = (r_count == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear || o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/anim_sequencer.sv
// -----------------------------------------------------------------------------
// anim_sequencer
// Per-player animation controller: turns game-logic inputs into a registered
// sprite frame code advanced on a fixed frame tick. Attack and injury
// animations play exactly once, reporting completion with anim_done.
// Optional feature: define ANIM_INJURED_EN to honour hit and enable INJURED.
// Ports:
//   i_clk              system clock
//   i_rst_n            asynchronous active-low reset
//   i_character_state  000 normal, 001 punch, 010 special (others = normal)
//   i_move_state       00/11 still, 01 forward, 10 backward
//   i_in_air           player airborne
//   i_hit              single-cycle strike pulse
//   o_sprite_sel       frame code for the renderer ROM mux
//   o_lock             high while a one-shot animation runs
//   o_anim_done        one-cycle pulse on the final tick of a one-shot
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | standing still on the ground
// ST_WALK_F  | walking forward, STAND/WALK_F alternate per tick
// ST_WALK_B  | walking backward, STAND/WALK_B alternate per tick
// ST_AIR     | airborne, JUMP frame
// ST_PUNCH   | one-shot PUNCH1..3, locked
// ST_SPECIAL | one-shot SP1..3, locked
// ST_INJURED | one-shot INJ1..3, locked (only with ANIM_INJURED_EN)
// -----------------------------------------------------------------------------
module anim_sequencer
  import anim_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_character_state,
  input  logic [1:0] i_move_state,
  input  logic       i_in_air,
  input  logic       i_hit,
  output logic [3:0] o_sprite_sel,
  output logic       o_lock,
  output logic       o_anim_done
);

  anim_state_t r_state;
  logic [1:0]  r_frame;
  logic        r_phase;
  logic [3:0]  r_sprite_sel;
  logic        r_lock;
  logic        r_anim_done;

  anim_state_t w_state_nxt;
  anim_state_t w_loco;
  logic [1:0]  w_frame_nxt;
  logic        w_phase_nxt;
  logic        w_enter;
  logic        w_done;
  logic        w_tick;
  logic        w_hit;

`ifdef ANIM_INJURED_EN
  assign w_hit = i_hit;
`else
  logic w_unused_hit;
  assign w_unused_hit = i_hit;
  assign w_hit        = 1'b0;
`endif

  anim_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (w_enter),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_loco = ST_IDLE;
    if (i_in_air) begin
      w_loco = ST_AIR;
    end else if (i_move_state == MV_FWD) begin
      w_loco = ST_WALK_F;
    end else if (i_move_state == MV_BWD) begin
      w_loco = ST_WALK_B;
    end
  end

  // Next-state decision; w_enter marks any state entry (including an INJURED
  // restart) so frame, phase and the tick counter all restart together.
  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame;
    w_phase_nxt = r_phase;
    w_enter     = 1'b0;
    w_done      = 1'b0;

    if (w_hit) begin
      w_state_nxt = ST_INJURED;
      w_enter     = 1'b1;
    end else if (!is_oneshot(r_state) && (i_character_state == CS_PUNCH)) begin
      w_state_nxt = ST_PUNCH;
      w_enter     = 1'b1;
    end else if (!is_oneshot(r_state) && (i_character_state == CS_SPECIAL)) begin
      w_state_nxt = ST_SPECIAL;
      w_enter     = 1'b1;
    end else if (is_oneshot(r_state)) begin
      if (w_tick) begin
        if (r_frame == LAST_FRAME) begin
          w_done      = 1'b1;
          w_state_nxt = w_loco;
          w_enter     = 1'b1;
        end else begin
          w_frame_nxt = r_frame + 2'd1;
        end
      end
    end else if (w_loco != r_state) begin
      w_state_nxt = w_loco;
      w_enter     = 1'b1;
    end else if (w_tick && ((r_state == ST_WALK_F) || (r_state == ST_WALK_B))) begin
      w_phase_nxt = ~r_phase;
    end

    if (w_enter) begin
      w_frame_nxt = 2'd0;
      w_phase_nxt = 1'b0;
    end
  end

  // Outputs are derived from the next state so they change on the same edge
  // as the state they describe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_frame      <= 2'd0;
      r_phase      <= 1'b0;
      r_sprite_sel <= SPR_STAND;
      r_lock       <= 1'b0;
      r_anim_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame      <= w_frame_nxt;
      r_phase      <= w_phase_nxt;
      r_sprite_sel <= sprite_code(w_state_nxt, w_frame_nxt, w_phase_nxt);
      r_lock       <= is_oneshot(w_state_nxt);
      r_anim_done  <= w_done;
    end
  end

  assign o_sprite_sel = r_sprite_sel;
  assign o_lock       = r_lock;
  assign o_anim_done  = r_anim_done;

endmodule

// File: tb/tb_anim_sequencer.sv
// -----------------------------------------------------------------------------
// tb_anim_sequencer
// Directed scenarios followed by random stimulus, checked against a
// timestamp-based reference model: each animation is described by its kind
// and the edge it started on; the shown frame is derived from elapsed edges.
// Honours ANIM_INJURED_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_anim_sequencer;

  localparam int TD = 4;

`ifdef ANIM_INJURED_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  // model animation kinds
  localparam int K_IDLE  = 0;
  localparam int K_WF    = 1;
  localparam int K_WB    = 2;
  localparam int K_AIR   = 3;
  localparam int K_PUNCH = 10;
  localparam int K_SPEC  = 11;
  localparam int K_INJ   = 12;

  logic       clk;
  logic       rst_n;
  logic [2:0] character_state;
  logic [1:0] move_state;
  logic       in_air;
  logic       hit;
  logic [3:0] sprite_sel;
  logic       lock;
  logic       anim_done;

  int n_chk;
  int n_fail;
  int n_edge;
  int m_kind;
  int m_t0;
  bit m_done;

  anim_sequencer #(
    .TICK_DIV (TD)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_character_state (character_state),
    .i_move_state      (move_state),
    .i_in_air          (in_air),
    .i_hit             (hit),
    .o_sprite_sel      (sprite_sel),
    .o_lock            (lock),
    .o_anim_done       (anim_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int loco_kind();
    if (in_air) return K_AIR;
    if (move_state == 2'b01) return K_WF;
    if (move_state == 2'b10) return K_WB;
    return K_IDLE;
  endfunction

  function automatic int exp_sprite();
    int k;
    k = n_edge - m_t0;
    case (m_kind)
      K_WF:    return ((k / TD) % 2 == 1) ? 1 : 0;
      K_WB:    return ((k / TD) % 2 == 1) ? 2 : 0;
      K_AIR:   return 12;
      K_PUNCH: return 3 + k / TD;
      K_SPEC:  return 6 + k / TD;
      K_INJ:   return 9 + k / TD;
      default: return 0;
    endcase
  endfunction

  // Applies the rules for one clock edge using the inputs held across it.
  task automatic model_edge();
    int  lk;
    bit  os;
    lk     = loco_kind();
    os     = (m_kind >= K_PUNCH);
    m_done = 1'b0;
    if (HIT_EN && hit) begin
      m_kind = K_INJ;
      m_t0   = n_edge;
    end else if (!os && (character_state == 3'b001)) begin
      m_kind = K_PUNCH;
      m_t0   = n_edge;
    end else if (!os && (character_state == 3'b010)) begin
      m_kind = K_SPEC;
      m_t0   = n_edge;
    end else if (os) begin
      if (n_edge - m_t0 == 3 * TD) begin
        m_done = 1'b1;
        m_kind = lk;
        m_t0   = n_edge;
      end
    end else if (lk != m_kind) begin
      m_kind = lk;
      m_t0   = n_edge;
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] es;
    logic       el;
    es = 4'(exp_sprite());
    el = (m_kind >= K_PUNCH);
    n_chk++;
    assert (sprite_sel === es) else begin
      n_fail++;
      $error("FAIL %s sprite_sel got %0d want %0d (edge %0d)", tag, sprite_sel, es, n_edge);
    end
    n_chk++;
    assert (lock === el) else begin
      n_fail++;
      $error("FAIL %s lock got %0b want %0b (edge %0d)", tag, lock, el, n_edge);
    end
    n_chk++;
    assert (anim_done === m_done) else begin
      n_fail++;
      $error("FAIL %s anim_done got %0b want %0b (edge %0d)", tag, anim_done, m_done, n_edge);
    end
  endtask

  task automatic expect4(input string tag, input logic [3:0] got, input logic [3:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s got %0d want %0d (edge %0d)", tag, got, want, n_edge);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    n_edge++;
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic model_reset();
    m_kind = K_IDLE;
    m_t0   = n_edge;
    m_done = 1'b0;
  endtask

  initial begin
    character_state = 3'b000;
    move_state      = 2'b00;
    in_air          = 1'b0;
    hit             = 1'b0;
    rst_n           = 1'b0;
    n_chk  = 0;
    n_fail = 0;
    n_edge = 0;
    model_reset();

    // reset state
    #22;
    expect4("rst_sprite", sprite_sel, 4'd0);
    expect4("rst_lock",   {3'b000, lock}, 4'd0);
    expect4("rst_done",   {3'b000, anim_done}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step("idle");

    // walk forward: 0,1,0,1 each for TD cycles
    move_state = 2'b01;
    for (int i = 0; i < 16; i++) begin
      step("walk");
      expect4("walk_seq", sprite_sel, ((i / TD) % 2 == 1) ? 4'd1 : 4'd0);
      expect4("walk_lock", {3'b000, lock}, 4'd0);
    end
    move_state = 2'b00;
    step("walk_stop");

    // punch from a single-cycle request
    character_state = 3'b001;
    for (int k = 0; k <= 3 * TD; k++) begin
      step("punch");
      if (k == 0) character_state = 3'b000;
      expect4("punch_seq", sprite_sel, (k < 3 * TD) ? 4'(3 + k / TD) : 4'd0);
      expect4("punch_lock", {3'b000, lock}, (k < 3 * TD) ? 4'd1 : 4'd0);
      expect4("punch_done", {3'b000, anim_done}, (k == 3 * TD) ? 4'd1 : 4'd0);
    end

    // special with a punch request arriving at frame 1, held past completion
    character_state = 3'b010;
    for (int k = 0; k <= 3 * TD; k++) begin
      step("special");
      if (k == 0) character_state = 3'b000;
      if (k == TD + 1) character_state = 3'b001;
      expect4("special_seq", sprite_sel, (k < 3 * TD) ? 4'(6 + k / TD) : 4'd0);
      expect4("special_done", {3'b000, anim_done}, (k == 3 * TD) ? 4'd1 : 4'd0);
    end
    step("punch_restart");
    expect4("punch_restart_sprite", sprite_sel, 4'd3);
    character_state = 3'b000;
    for (int k = 1; k <= 3 * TD; k++) step("punch_restart_run");

`ifdef ANIM_INJURED_EN
    // hit at frame 1 of a punch aborts it
    character_state = 3'b001;
    step("pre_hit_punch");
    character_state = 3'b000;
    for (int k = 1; k <= TD + 1; k++) step("pre_hit_punch");
    hit = 1'b1;
    step("hit");
    hit = 1'b0;
    expect4("hit_sprite", sprite_sel, 4'd9);
    expect4("hit_no_done", {3'b000, anim_done}, 4'd0);
    for (int j = 1; j <= 3 * TD; j++) begin
      step("injured");
      expect4("injured_seq", sprite_sel, (j < 3 * TD) ? 4'(9 + j / TD) : 4'd0);
      expect4("injured_done", {3'b000, anim_done}, (j == 3 * TD) ? 4'd1 : 4'd0);
    end
    // hit and attack together, then a second hit restarting INJURED
    character_state = 3'b001;
    hit = 1'b1;
    step("hit_vs_attack");
    hit = 1'b0;
    character_state = 3'b000;
    expect4("hit_wins", sprite_sel, 4'd9);
    for (int j = 1; j <= 2 * TD + 2; j++) step("injured2");
    hit = 1'b1;
    step("hit_restart");
    hit = 1'b0;
    expect4("hit_restart_sprite", sprite_sel, 4'd9);
    for (int j = 1; j <= 3 * TD; j++) step("injured3");
`else
    // hit ignored without the injured feature
    hit = 1'b1;
    step("hit_ignored");
    hit = 1'b0;
    expect4("hit_ign_sprite", sprite_sel, 4'd0);
    expect4("hit_ign_lock", {3'b000, lock}, 4'd0);
    for (int j = 0; j < 3; j++) step("hit_ignored_after");
`endif

    // asynchronous reset in the middle of a punch
    character_state = 3'b001;
    step("pre_rst");
    character_state = 3'b000;
    for (int k = 0; k < 5; k++) step("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    expect4("async_rst_sprite", sprite_sel, 4'd0);
    expect4("async_rst_lock", {3'b000, lock}, 4'd0);
    expect4("async_rst_done", {3'b000, anim_done}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step("post_rst");
    expect4("post_rst_sprite", sprite_sel, 4'd0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      if ($urandom_range(0, 7) == 0) move_state = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) in_air = ~in_air;
      r = $urandom_range(0, 31);
      if (r < 2)       character_state = 3'b001;
      else if (r == 2) character_state = 3'b010;
      else if (r == 3) character_state = 3'($urandom_range(3, 7));
      else             character_state = 3'b000;
      hit = ($urandom_range(0, 40) == 0);
      step("rand");
    end
    hit = 1'b0;
    character_state = 3'b000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
